// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for the sync_memory slice.
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Storage: one write port, one registered read port, no reset on the array.
// Latency: read data valid the cycle after rd_en; write lands on the sampling edge.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_memory.sv
// Single-port memory with zero-fill sweep after reset or clear_req; ack one cycle after acceptance.
// Backpressure: ready low during the sweep, requests seen while not ready are dropped.
module sync_memory
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic              req,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    mem_state_e        state;
    logic [ADDR_W:0]   clr_ptr;
    logic              accept;
    logic              acc_q;
    logic              acc_we_q;
    logic [DATA_W-1:0] acc_wdat_q;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_dat;
    logic [DATA_W-1:0] mem_rd_dat;

    assign ready  = (state == ST_IDLE);
    assign accept = ready && req && !clear_req;

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = address;
        mem_wr_dat  = write_data;
        if (state == ST_CLEAR) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = clr_ptr[ADDR_W-1:0];
            mem_wr_dat  = '0;
        end else begin
            mem_wr_en   = accept && write_enable;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_dat  (mem_wr_dat),
        .rd_en   (accept),
        .rd_addr (address),
        .rd_dat  (mem_rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            acc_q      <= 1'b0;
            acc_we_q   <= 1'b0;
            acc_wdat_q <= '0;
            ack        <= 1'b0;
            read_data  <= '0;
        end else begin
            // The ack owed from the previous edge is issued even if this edge enters CLEAR.
            ack   <= acc_q;
            acc_q <= accept;
            if (acc_q) begin
                read_data <= acc_we_q ? acc_wdat_q : mem_rd_dat;
            end
            if (accept) begin
                acc_we_q   <= write_enable;
                acc_wdat_q <= write_data;
            end
            case (state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                        if (clr_ptr == LAST_PTR) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_memory.sv
// Directed bench for sync_memory: default 8x32 instance plus a 16x16 instance.
module tb_sync_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        clear_req8 = 1'b0, req8 = 1'b0, we8 = 1'b0;
    logic [4:0]  addr8 = '0;
    logic [7:0]  wdat8 = '0;
    logic        ready8, ack8;
    logic [7:0]  rdat8;

    logic        clear_req16 = 1'b0, req16 = 1'b0, we16 = 1'b0;
    logic [3:0]  addr16 = '0;
    logic [15:0] wdat16 = '0;
    logic        ready16, ack16;
    logic [15:0] rdat16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_memory u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_req    (clear_req8),
        .req          (req8),
        .write_enable (we8),
        .address      (addr8),
        .write_data   (wdat8),
        .ready        (ready8),
        .ack          (ack8),
        .read_data    (rdat8)
    );

    sync_memory #(.DATA_W(16), .ADDR_W(4)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_req    (clear_req16),
        .req          (req16),
        .write_enable (we16),
        .address      (addr16),
        .write_data   (wdat16),
        .ready        (ready16),
        .ack          (ack16),
        .read_data    (rdat16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready (bounded), noting any ack seen on the way.
    task automatic wait_ready(input bit which, input string tag, input int exp_edges);
        int n = 0;
        bit saw_ack = 1'b0;
        bit r = 1'b0;
        while (!r && n < 64) begin
            step();
            n++;
            r       = which ? ready16 : ready8;
            saw_ack = saw_ack | (which ? ack16 : ack8);
        end
        chk({tag, "_edges"}, n, exp_edges);
        chk({tag, "_noack"}, saw_ack, 0);
    endtask

    task automatic acc(input bit which, input logic we, input logic [4:0] a,
                       input logic [15:0] d, input logic [15:0] exp, input string tag);
        if (which) begin
            req16 = 1'b1; we16 = we; addr16 = a[3:0]; wdat16 = d;
        end else begin
            req8 = 1'b1; we8 = we; addr8 = a; wdat8 = d[7:0];
        end
        step();
        req8 = 1'b0; req16 = 1'b0;
        chk({tag, "_ack_lat0"}, which ? ack16 : ack8, 0);
        step();
        chk({tag, "_ack"}, which ? ack16 : ack8, 1);
        chk({tag, "_rd"}, which ? rdat16 : {8'h0, rdat8}, exp);
    endtask

    initial begin
        int r8_edge = 0;
        int r16_edge = 0;
        bit ack_seen = 1'b0;

        repeat (3) step();
        chk("rst_ready8", ready8, 0);
        chk("rst_ack8", ack8, 0);
        chk("rst_rd8", rdat8, 0);
        chk("rst_ready16", ready16, 0);
        chk("rst_rd16", rdat16, 0);

        // Release, sweep both; a write attempt lands on edge 10 mid-sweep.
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                req8 = 1'b1; we8 = 1'b1; addr8 = 5'd3; wdat8 = 8'hFF;
            end
            step();
            req8 = 1'b0;
            if (ack8) ack_seen = 1'b1;
            if (ready8 && r8_edge == 0) r8_edge = k;
            if (ready16 && r16_edge == 0) r16_edge = k;
        end
        chk("sweep_edges8", r8_edge, 32);
        chk("sweep_edges16", r16_edge, 16);
        chk("clear_req_ignored_noack", ack_seen, 0);

        for (int a = 0; a < 32; a++) begin
            acc(1'b0, 1'b0, 5'(a), 16'h0, 16'h0, $sformatf("zero_rd%0d", a));
        end

        acc(1'b0, 1'b1, 5'd3, 16'h00A5, 16'h00A5, "wr3");
        acc(1'b0, 1'b0, 5'd3, 16'h0000, 16'h00A5, "rd3");

        // Back-to-back writes then reads.
        req8 = 1'b1; we8 = 1'b1; addr8 = 5'd1; wdat8 = 8'h5A;
        step();
        chk("b2b_ack0", ack8, 0);
        addr8 = 5'd2; wdat8 = 8'hC3;
        step();
        chk("b2b_ack1", ack8, 1); chk("b2b_rd1", rdat8, 8'h5A);
        we8 = 1'b0; addr8 = 5'd1;
        step();
        chk("b2b_ack2", ack8, 1); chk("b2b_rd2", rdat8, 8'hC3);
        addr8 = 5'd2;
        step();
        chk("b2b_ack3", ack8, 1); chk("b2b_rd3", rdat8, 8'h5A);
        req8 = 1'b0;
        step();
        chk("b2b_ack4", ack8, 1); chk("b2b_rd4", rdat8, 8'hC3);
        step();
        chk("b2b_ack_end", ack8, 0); chk("hold_rd_a", rdat8, 8'hC3);
        step();
        chk("hold_rd_b", rdat8, 8'hC3);

        // Ack owed from the last access survives entry to CLEAR.
        req8 = 1'b1; we8 = 1'b1; addr8 = 5'd2; wdat8 = 8'h11;
        step();
        req8 = 1'b0; clear_req8 = 1'b1;
        step();
        clear_req8 = 1'b0;
        chk("owed_ack", ack8, 1);
        chk("owed_rd", rdat8, 8'h11);
        chk("owed_ready_low", ready8, 0);
        wait_ready(1'b0, "clr_owed", 32);

        // clear_req with simultaneous req: request dropped, word 7 zeroed.
        acc(1'b0, 1'b1, 5'd7, 16'h003C, 16'h003C, "wr7");
        clear_req8 = 1'b1; req8 = 1'b1; we8 = 1'b1; addr8 = 5'd7; wdat8 = 8'h77;
        step();
        clear_req8 = 1'b0; req8 = 1'b0;
        chk("clr_win_ack0", ack8, 0);
        wait_ready(1'b0, "clr_win", 32);
        acc(1'b0, 1'b0, 5'd7, 16'h0, 16'h0, "rd7_cleared");

        // clear_req during the sweep restarts it.
        clear_req8 = 1'b1;
        step();
        clear_req8 = 1'b0;
        repeat (5) step();
        clear_req8 = 1'b1;
        step();
        clear_req8 = 1'b0;
        wait_ready(1'b0, "clr_restart", 32);

        // Reset pulse mid-sweep at word 15.
        acc(1'b0, 1'b1, 5'd20, 16'h0099, 16'h0099, "wr20");
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", ready8, 0);
        chk("rst_async_rd", rdat8, 0);
        step();
        rst_n = 1'b1;
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        chk("midsweep_rst_ready", ready8, 0);
        step();
        rst_n = 1'b1;
        wait_ready(1'b0, "midsweep_rst", 32);
        acc(1'b0, 1'b0, 5'd20, 16'h0, 16'h0, "rd20_cleared");

        // Wide/shallow instance.
        chk("w16_ready", ready16, 1);
        acc(1'b1, 1'b1, 5'd15, 16'hBEEF, 16'hBEEF, "w16_wr15");
        acc(1'b1, 1'b0, 5'd15, 16'h0, 16'hBEEF, "w16_rd15");
        acc(1'b1, 1'b0, 5'd0, 16'h0, 16'h0, "w16_rd0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_memory.md
SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_req  input  1  one-cycle pulse requesting a full zero-fill of the array.
REQ-006 SHALL have port req  input  1  access request, sampled only while ready=1.
REQ-007 SHALL have port write_enable  input  1  qualifies req as write (1) or read (0).
REQ-008 SHALL have port address  input  ADDR_W  word address of the access.
REQ-009 SHALL have port write_data  input  DATA_W  data for write accesses.
REQ-010 SHALL have port ready  output  1  high only in IDLE; accesses accepted.
REQ-011 SHALL have port ack  output  1  one-cycle pulse, one per accepted req.
REQ-012 SHALL have port read_data  output  DATA_W  registered result of the last acked access.

Function
REQ-013 SHALL implement FSM states CLEAR and IDLE, encoded as a shared enum.
REQ-014 In CLEAR, each clk edge SHALL write zero to mem[clr_ptr] and increment clr_ptr (ADDR_W+1 bits) from 0.
REQ-015 CLEAR SHALL exit to IDLE on the edge that writes word DEPTH-1; ready SHALL be 1 from that edge, i.e. exactly DEPTH edges after clearing starts.
REQ-016 In IDLE, req=1 SHALL be accepted on a clk edge; req while ready=0 SHALL be ignored, with no ack ever issued for it.
REQ-017 Accepted write SHALL update mem[address] on the accepting edge; every other word SHALL be unchanged.
REQ-018 ack SHALL pulse high for exactly one cycle, on the edge after acceptance (1-cycle latency); back-to-back reqs SHALL give back-to-back acks.
REQ-019 On read ack, read_data SHALL equal mem[address] as of the accepting edge.
REQ-020 On write ack, read_data SHALL equal the written write_data (write-first).
REQ-021 read_data SHALL hold its value between acks.
REQ-022 clear_req in IDLE SHALL enter CLEAR with clr_ptr=0 on the next edge; a req on the same edge SHALL be dropped (clear wins, no ack, no write).
REQ-023 clear_req during CLEAR SHALL restart the sweep at clr_ptr=0.
REQ-024 An ack owed from the last IDLE access SHALL still be issued on the edge that enters CLEAR.
REQ-025 Address wrap: none needed; every ADDR_W value is a valid word.

Reset
REQ-026 rst_n=0 SHALL immediately force state=CLEAR, clr_ptr=0, ready=0, ack=0, read_data=0.
REQ-027 The array SHALL NOT be reset directly; it SHALL be zeroed only by the CLEAR sweep after rst_n rises.
REQ-028 rst_n asserted mid-sweep or mid-access SHALL abort it; the sweep SHALL restart from word 0 on release.

Structure
REQ-029 Package mem_pkg SHALL hold the state enum typedef and the default DATA_W/ADDR_W constants.
REQ-030 Storage SHALL be one sub-module mem_array (one write port, one synchronous read port, parameterised DATA_W/ADDR_W); sync_memory SHALL hold the FSM, clear pointer and handshake.

Verification
REQ-031 Reset release, defaults -> ready rises exactly 32 edges later; a read of every address returns 0x00.
REQ-032 Write 0xA5 @3, then read @3 -> each acks 1 cycle after acceptance; write ack read_data=0xA5, read ack read_data=0xA5.
REQ-033 req during CLEAR (cycle 10 after reset) -> no ack; mem unchanged after sweep.
REQ-034 Write 0x3C @7, then clear_req+req same edge -> no ack for req; after 32 edges, read @7 = 0x00.
REQ-035 rst_n pulse at sweep word 15 -> ready rises 32 edges after release, not 17.
REQ-036 DATA_W=16, ADDR_W=4: write 0xBEEF @15, read @15 -> 0xBEEF; ready 16 edges after reset.
